// File: rtl/gray_monitor.sv
// Gray-code counter monitor: synchronises an upstream Gray count, decodes it
// to binary, checks that consecutive samples only hold or advance by one, and
// counts forward wraps through zero.
`timescale 1ns/1ps

module gray_monitor #(
    parameter int unsigned CBITS = 9,
    parameter int unsigned WBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] gray_in,
    input  logic             clr_err,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             wrap_pulse,
    output logic [WBITS-1:0] wrap_cnt,
    output logic             step_err,
    output logic             err_sticky,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Edges after reset release until prev holds a genuinely sampled value.
    localparam int unsigned WARM_BITS = 4;
    localparam logic [CBITS-1:0] ALL_ONES = '1;
    localparam logic [WBITS-1:0] CNT_MAX  = '1;

    logic [CBITS-1:0]     s1;
    logic [CBITS-1:0]     s2;
    logic [CBITS-1:0]     dec;
    logic [CBITS-1:0]     prev;
    logic [WARM_BITS-1:0] warm;
    logic                 chk_arm;
    logic                 check_en;
    logic                 is_hold;
    logic                 is_step;
    logic                 is_wrap;

    state_t           st;
    state_t           st_nxt;
    logic             step_err_nxt;
    logic             wrap_nxt;
    logic [WBITS-1:0] cnt_nxt;

    // Two-flop synchroniser for the asynchronous Gray input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < int'(CBITS); i++) begin
            dec[i] = ^(s2 >> i);
        end
    end

    // Decoded sample, its predecessor and the pipeline warm-up tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_out <= '0;
            prev    <= '0;
            warm    <= '0;
            chk_arm <= 1'b0;
        end else begin
            bin_out <= dec;
            prev    <= bin_out;
            warm    <= {warm[WARM_BITS-2:0], 1'b1};
            chk_arm <= (st == ST_RUN);
        end
    end

    // Transition classification of the current sample against the previous one.
    always_comb begin
        is_hold  = (bin_out == prev);
        is_step  = (bin_out == CBITS'(prev + CBITS'(1)));
        is_wrap  = (prev == ALL_ONES) && (bin_out == '0);
        check_en = chk_arm && warm[WARM_BITS-1];
    end

    // Next-state and next-output logic; an illegal step outranks clr_err.
    always_comb begin
        st_nxt       = st;
        step_err_nxt = 1'b0;
        wrap_nxt     = 1'b0;
        cnt_nxt      = wrap_cnt;
        case (st)
            ST_INIT: begin
                st_nxt  = ST_RUN;
                cnt_nxt = '0;
            end
            ST_RUN: begin
                if (check_en) begin
                    if (!is_hold && !is_step) begin
                        st_nxt       = ST_FAULT;
                        step_err_nxt = 1'b1;
                    end else if (is_wrap) begin
                        wrap_nxt = 1'b1;
                        if (wrap_cnt != CNT_MAX) begin
                            cnt_nxt = WBITS'(wrap_cnt + WBITS'(1));
                        end
                    end
                end
            end
            ST_FAULT: begin
                if (clr_err) begin
                    st_nxt  = ST_INIT;
                    cnt_nxt = '0;
                end
            end
            default: begin
                st_nxt = ST_INIT;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= ST_INIT;
            step_err   <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            bin_vld    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            st         <= st_nxt;
            step_err   <= step_err_nxt;
            wrap_pulse <= wrap_nxt;
            wrap_cnt   <= cnt_nxt;
            bin_vld    <= (st_nxt == ST_RUN);
            err_sticky <= (st_nxt == ST_FAULT);
        end
    end

    assign state = st;

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 SHALL have parameter CBITS, default 9, giving the Gray-code width.
REQ-002 SHALL have parameter WBITS, default 8, giving the wrap-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low: rst=0 resets immediately; release is sampled on clk.
REQ-005 gray_in  input  CBITS  Gray-coded count from the upstream counter; may be asynchronous to clk.
REQ-006 clr_err  input  1  synchronous request to leave FAULT.
REQ-007 bin_out  output  CBITS  registered binary decode of the synchronised gray_in.
REQ-008 bin_vld  output  1  high when bin_out holds a decoded sample, i.e. in RUN.
REQ-009 wrap_pulse  output  1  one-cycle pulse on a forward wrap from all-ones to 0.
REQ-010 wrap_cnt  output  WBITS  number of wraps since reset or INIT; saturating.
REQ-011 step_err  output  1  one-cycle pulse on an illegal transition.
REQ-012 err_sticky  output  1  high while in FAULT.
REQ-013 state  output  2  FSM state: INIT=0, RUN=1, FAULT=2; 3 is unused.

Function
REQ-014 SHALL pass gray_in through a two-flop synchronizer (s1, then s2) with no other logic.
REQ-015 SHALL decode s2 to binary: b[CBITS-1]=g[CBITS-1]; b[i]=b[i+1]^g[i].
REQ-016 SHALL register the decoded value in bin_out every cycle, including in INIT and FAULT.
REQ-017 SHALL have a latency of 3 rising edges from a gray_in value stable at edge N to bin_out valid after edge N+2.
REQ-018 SHALL keep prev, the bin_out value of the previous cycle, for transition checks.
REQ-019 SHALL classify each cycle in RUN by comparing new bin_out with prev:
- HOLD: equal values.
- STEP: new = prev+1 modulo 2^CBITS.
- ILLEGAL: any other relation, including -1 (back-step) or a multi-bit Gray change.
REQ-020 FSM INIT SHALL go to RUN after one cycle, loading prev without any check.
REQ-021 FSM RUN SHALL stay in RUN on HOLD or STEP.
REQ-022 FSM RUN SHALL go to FAULT on ILLEGAL and pulse step_err for exactly one cycle.
REQ-023 FSM FAULT SHALL ignore transitions, hold wrap_cnt, and raise no further step_err.
REQ-024 FSM FAULT with clr_err=1 SHALL go to INIT on the next edge and clear wrap_cnt.
REQ-025 SHALL ignore clr_err outside FAULT.
REQ-026 wrap_pulse SHALL be 1 for one cycle, only in RUN, when prev = 2^CBITS-1 and new bin_out = 0.
REQ-027 On a wrap, wrap_cnt SHALL increment in that same cycle and saturate at 2^WBITS-1 without rolling over.
REQ-028 bin_vld SHALL be 1 exactly when state=RUN.
REQ-029 An ILLEGAL transition from all-ones to a nonzero value SHALL fault, with no wrap_pulse.
REQ-030 If ILLEGAL and clr_err occur together in RUN, ILLEGAL SHALL win (go to FAULT).

Reset
REQ-031 While rst=0, outputs SHALL be held: s1, s2, bin_out, prev and wrap_cnt = 0; wrap_pulse, step_err and err_sticky = 0; bin_vld = 0; state = INIT.
REQ-032 Reset asserted mid-operation (any state) SHALL force the REQ-031 values asynchronously.
REQ-033 After release, the first RUN cycle SHALL perform no check; the first sample after reset never faults.
REQ-034 There SHALL be no latch-based or combinational paths from gray_in to any output.

Verification (CBITS=9, WBITS=8)
REQ-035 Reset: hold rst=0 for 3 cycles -> all outputs 0 and state=INIT; after release -> state=RUN after one edge.
REQ-036 Count: drive gray(0)..gray(20), one per cycle -> bin_out 0..20 lagging by 3 edges, with step_err=0 and wrap_pulse=0 throughout.
REQ-037 Wrap: drive gray(509), gray(510), gray(511)=0x100, then gray(0) -> one wrap_pulse when bin_out goes 511->0, and wrap_cnt=1.
REQ-038 Illegal jumps, each checked separately:
- gray(5)=0x007 to gray(4)=0x006 (back-step) -> step_err pulses once, state=FAULT, err_sticky=1.
- gray(2)=0x003 to 0x000 (two-bit change) -> same response.
REQ-039 Recovery: in FAULT pulse clr_err -> state INIT, then RUN; wrap_cnt=0; no step_err on the first sample.
REQ-040 Saturation and mid-reset: force 300 wraps -> wrap_cnt stays at 255; then assert rst mid-count -> outputs zero within the same cycle.
